// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the execute-stage control unit and mdu_iter.
interface mdu_iter_if #(parameter int XLEN = 32);
   logic            start;
   logic [2:0]      func3;
   logic [XLEN-1:0] a, b;
   logic            busy, done, illegal;
   logic [XLEN-1:0] result;
   modport master (output start, func3, a, b, input busy, done, result, illegal);
   modport slave (input start, func3, a, b, output busy, done, result, illegal);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M/RV64M unit, shift-add multiply and restoring divide on magnitudes.
// Macro MDU_DIV_EN builds the divider; without it func3[2] ops finish at once with illegal=1.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       reset,
   mdu_iter_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2:0]          op;
   logic                neg;
   logic [XLEN-1:0]     mcand;
   logic [2*XLEN-1:0]   prod;
   logic                accept, sgn_a, sgn_b, ea, eb;
   logic [XLEN-1:0]     mag_a, mag_b, mul_res, fix_res;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   prod_fix, mul_next;
   assign accept   = bus.start & ((state == IDLE) | (state == DONE));
   assign sgn_a    = (bus.func3 == 3'b001) | (bus.func3 == 3'b010) | (bus.func3[2] & ~bus.func3[0]);
   assign sgn_b    = (bus.func3 == 3'b001) | (bus.func3[2] & ~bus.func3[0]);
   assign ea       = sgn_a & bus.a[XLEN-1];
   assign eb       = sgn_b & bus.b[XLEN-1];
   assign mag_a    = ea ? -bus.a : bus.a;
   assign mag_b    = eb ? -bus.b : bus.b;
   // prod holds {partial high half, remaining multiplier bits}; each step shifts right by one
   assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
   assign mul_next = {mul_sum, prod[XLEN-1:1]};
   assign prod_fix = neg ? -prod : prod;
   assign mul_res  = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
   logic                sa;
   logic [XLEN:0]       rem_sh, div_diff;
   logic [2*XLEN-1:0]   div_next;
   logic [XLEN-1:0]     quo, rem;
   // divide reuses prod as {remainder, dividend/quotient}, shifting left each step
   assign rem_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
   assign div_diff = rem_sh - {1'b0, mcand};
   assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
   // a zero divisor yields quotient all ones and remainder |a| naturally; only signs need care
   assign quo      = neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
   assign rem      = sa ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
   assign fix_res  = op[2] ? (op[1] ? rem : quo) : mul_res;
`else
   assign fix_res  = op[2] ? '0 : mul_res;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         op          <= '0;
         neg         <= 1'b0;
         mcand       <= '0;
         prod        <= '0;
`ifdef MDU_DIV_EN
         sa          <= 1'b0;
`endif
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         bus.result  <= '0;
      end else begin
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         if (accept) begin
            op       <= bus.func3;
            neg      <= (ea ^ eb) & ~(bus.func3[2] & (bus.b == '0));
            mcand    <= mag_b;
            prod     <= {{XLEN{1'b0}}, mag_a};
            cnt      <= CW'(XLEN - 1);
            bus.busy <= 1'b1;
`ifdef MDU_DIV_EN
            sa       <= ea;
            state    <= RUN;
`else
            state    <= bus.func3[2] ? FIX : RUN;
`endif
         end else if (state == RUN) begin
`ifdef MDU_DIV_EN
            prod <= op[2] ? div_next : mul_next;
`else
            prod <= mul_next;
`endif
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
         end else if (state == FIX) begin
            bus.result <= fix_res;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
`ifndef MDU_DIV_EN
            bus.illegal <= op[2];
`endif
            state <= DONE;
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized scoreboard bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;
   localparam int X = 32;
   localparam bit DIV_EN =
`ifdef MDU_DIV_EN
      1'b1;
`else
      1'b0;
`endif
   typedef struct {logic [X-1:0] res; logic ill; int lat; int t0;} exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   errors = 0;
   int   n;
   exp_t sb[$];

   mdu_iter_if #(.XLEN(X)) bus ();
   mdu_iter #(.XLEN(X)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // RISC-V M semantics from plain wide arithmetic; returns {illegal, result}
   function automatic logic [X:0] model(input logic [2:0] f, input logic [X-1:0] a, input logic [X-1:0] b);
      logic [2*X-1:0]    sx_a, sx_b, zx_a, zx_b, p;
      logic [X-1:0]      mn, q, r;
      logic signed [X-1:0] sq, sr;
      logic              bz, ovf;
      sx_a = {{X{a[X-1]}}, a};
      sx_b = {{X{b[X-1]}}, b};
      zx_a = {{X{1'b0}}, a};
      zx_b = {{X{1'b0}}, b};
      mn   = {1'b1, {(X-1){1'b0}}};
      bz   = (b == '0);
      ovf  = (a == mn) && (b == '1);
      if (f[2] && !DIV_EN) return {1'b1, {X{1'b0}}};
      sq = '0;
      sr = '0;
      if (!bz && !ovf) begin
         sq = $signed(a) / $signed(b);
         sr = $signed(a) % $signed(b);
      end
      case (f)
         3'd0: p = zx_a * zx_b;
         3'd1: p = sx_a * sx_b;
         3'd2: p = sx_a * zx_b;
         default: p = zx_a * zx_b;
      endcase
      q = bz ? '1 : ovf ? a : sq;
      r = bz ? a : ovf ? '0 : sr;
      case (f)
         3'd0: return {1'b0, p[X-1:0]};
         3'd4: return {1'b0, q};
         3'd5: return {1'b0, bz ? {X{1'b1}} : a / b};
         3'd6: return {1'b0, r};
         3'd7: return {1'b0, bz ? a : a % b};
         default: return {1'b0, p[2*X-1:X]};
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f);
      return (f[2] && !DIV_EN) ? 2 : X + 2;
   endfunction

   function automatic logic [X-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(X-1){1'b0}}};
         3: return X'(1);
         4: return X'($urandom_range(0, 255));
         default: return X'($urandom);
      endcase
   endfunction

   // caller is at a negedge with busy=0, so the request is accepted at the next posedge
   task automatic issue(input logic [2:0] f, input logic [X-1:0] a, input logic [X-1:0] b);
      exp_t e;
      logic [X:0] m;
      m = model(f, a, b);
      e.res = m[X-1:0];
      e.ill = m[X];
      e.lat = lat_of(f);
      e.t0 = cyc;
      bus.start = 1'b1;
      bus.func3 = f;
      bus.a = a;
      bus.b = b;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (bus.busy !== 1'b0 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      if (cnt >= 200) begin
         vectors++;
         errors++;
         $display("FAIL ready_timeout: busy still %b after %0d cycles, want 0", bus.busy, cnt);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL spurious_done: got done=1 with nothing pending, want done=0");
         end else begin
            e = sb.pop_front();
            check("result", 64'(bus.result), 64'(e.res));
            check("illegal", 64'(bus.illegal), 64'(e.ill));
            check("latency", 64'(cyc - e.t0), 64'(e.lat));
            check("busy_at_done", 64'(bus.busy), 64'(0));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, want completion");
      $fatal(1);
   end

   typedef struct {logic [2:0] f; logic [X-1:0] a; logic [X-1:0] b;} vec_t;
   vec_t dir[$];

   initial begin
      bus.start = 1'b0;
      bus.func3 = '0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_illegal", 64'(bus.illegal), 64'(0));
      check("rst_result", 64'(bus.result), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      dir = '{'{3'd0, 32'h0000_0007, 32'hFFFF_FFFD}, '{3'd1, 32'h8000_0000, 32'h8000_0000},
              '{3'd2, 32'h8000_0000, 32'h8000_0000}, '{3'd3, 32'h8000_0000, 32'h8000_0000},
              '{3'd4, 32'hFFFF_FFF9, 32'd2}, '{3'd6, 32'hFFFF_FFF9, 32'd2},
              '{3'd5, 32'd100, 32'd7}, '{3'd7, 32'd100, 32'd7},
              '{3'd5, 32'd5, 32'd0}, '{3'd6, 32'd5, 32'd0},
              '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF},
              '{3'd4, 32'hFFFF_FFF9, 32'd0}, '{3'd0, 32'h1234_5678, 32'h9ABC_DEF0}};
      foreach (dir[i]) begin
         issue(dir[i].f, dir[i].a, dir[i].b);
         wait_ready(n);
         check("busy_cycles", 64'(n), 64'(lat_of(dir[i].f) - 1));
      end
      // back-to-back: wait_ready returns in the done cycle; a new request must start at once
      check("b2b_done", 64'(bus.done), 64'(1));
      issue(3'd3, pick(), pick());
      check("b2b_busy", 64'(bus.busy), 64'(1));
      for (int k = 0; k < 10; k++) begin
         bus.start = 1'b1;
         bus.func3 = 3'($urandom_range(0, 7));
         bus.a = pick();
         bus.b = pick();
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_ready(n);
      issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
      wait_ready(n);
      issue(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(bus.busy), 64'(0));
      check("mid_rst_done", 64'(bus.done), 64'(0));
      check("mid_rst_result", 64'(bus.result), 64'(0));
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (X + 6) @(negedge clk);
      check("post_rst_busy", 64'(bus.busy), 64'(0));
      check("post_rst_result", 64'(bus.result), 64'(0));
      for (int i = 0; i < 150; i++) begin
         wait_ready(n);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(3'($urandom_range(0, 7)), pick(), pick());
      end
      wait_ready(n);
      repeat (3) @(negedge clk);
      check("queue_empty", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
